// File: rtl/alu_pkg.sv
// Shared types for the registered 4-bit ALU: opcode encoding, default width, flag bundle.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } opcode_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
  } alu_flags_t;

endpackage

// File: rtl/alu_comb.sv
// Purely combinational ALU datapath: opcode and operands to next result and flags.
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // Widened by one bit so the top bit is carry-out / borrow directly.
  assign sum  = {1'b0, op1} + {1'b0, op2};
  assign diff = {1'b0, op1} - {1'b0, op2};

  always_comb begin
    result      = '0;
    flags.carry = 1'b0;
    flags.ovf   = 1'b0;
    case (opcode_t'(opcode))
      OP_ADD: begin
        result      = sum[WIDTH-1:0];
        flags.carry = sum[WIDTH];
        flags.ovf   = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_SUB: begin
        result      = diff[WIDTH-1:0];
        flags.carry = diff[WIDTH];
        flags.ovf   = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_AND: result = op1 & op2;
      OP_OR:  result = op1 | op2;
      OP_XOR: result = op1 ^ op2;
      OP_NOT: result = ~op1;
      OP_SHL: begin
        result      = {op1[WIDTH-2:0], 1'b0};
        flags.carry = op1[WIDTH-1];
      end
      OP_SHR: begin
        result      = {1'b0, op1[WIDTH-1:1]};
        flags.carry = op1[0];
      end
      default: result = '0;
    endcase
    flags.zero = (result == '0);
    flags.neg  = result[WIDTH-1];
  end

endmodule

// File: rtl/alu_core.sv
// Registered ALU: alu_comb plus output registers and synchronous reset.
// Define ALU_FORMAL_EN to compile the reference-model assertions and covers.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       OPCODE,
  input  logic [WIDTH-1:0] OP1,
  input  logic [WIDTH-1:0] OP2,
  output logic [WIDTH-1:0] RESULT,
  output logic             CARRY,
  output logic             ZERO,
  output logic             NEG,
  output logic             OVF,
  output logic             VALID
);

  logic [WIDTH-1:0] next_result;
  alu_flags_t       next_flags;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .opcode (OPCODE),
    .op1    (OP1),
    .op2    (OP2),
    .result (next_result),
    .flags  (next_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      RESULT <= '0;
      CARRY  <= 1'b0;
      ZERO   <= 1'b0;
      NEG    <= 1'b0;
      OVF    <= 1'b0;
      VALID  <= 1'b0;
    end else begin
      RESULT <= next_result;
      CARRY  <= next_flags.carry;
      ZERO   <= next_flags.zero;
      NEG    <= next_flags.neg;
      OVF    <= next_flags.ovf;
      VALID  <= 1'b1;
    end
  end

`ifdef ALU_FORMAL_EN
  logic [WIDTH-1:0] past_op1;
  logic [WIDTH-1:0] past_op2;
  logic [2:0]       past_opcode;
  logic             past_rst;
  logic             past_valid;
  logic [WIDTH-1:0] ref_result;
  logic             ref_carry;
  logic             ref_ovf;

  // past_valid means a reset edge has been seen, so the outputs are defined.
  always_ff @(posedge clk) begin
    past_op1    <= OP1;
    past_op2    <= OP2;
    past_opcode <= OPCODE;
    past_rst    <= rst;
    if (rst) past_valid <= 1'b1;
  end

  always_comb begin
    ref_result = '0;
    ref_carry  = 1'b0;
    ref_ovf    = 1'b0;
    case (past_opcode)
      3'b000: begin
        {ref_carry, ref_result} = {1'b0, past_op1} + {1'b0, past_op2};
        ref_ovf = (past_op1[WIDTH-1] ~^ past_op2[WIDTH-1]) & (ref_result[WIDTH-1] ^ past_op1[WIDTH-1]);
      end
      3'b001: begin
        ref_result = past_op1 - past_op2;
        ref_carry  = (past_op1 < past_op2);
        ref_ovf    = (past_op1[WIDTH-1] ^ past_op2[WIDTH-1]) & (ref_result[WIDTH-1] ^ past_op1[WIDTH-1]);
      end
      3'b010: ref_result = past_op1 & past_op2;
      3'b011: ref_result = past_op1 | past_op2;
      3'b100: ref_result = past_op1 ^ past_op2;
      3'b101: ref_result = ~past_op1;
      3'b110: begin
        ref_result = past_op1 << 1;
        ref_carry  = past_op1[WIDTH-1];
      end
      default: begin
        ref_result = past_op1 >> 1;
        ref_carry  = past_op1[0];
      end
    endcase
  end

  a_compute: assert property (@(posedge clk) (past_valid && !past_rst) |->
    (RESULT == ref_result && CARRY == ref_carry && OVF == ref_ovf &&
     ZERO == (ref_result == '0) && NEG == ref_result[WIDTH-1] && VALID));

  a_reset: assert property (@(posedge clk) (past_valid && past_rst) |->
    (RESULT == '0 && !CARRY && !ZERO && !NEG && !OVF && !VALID));

  for (genvar g = 0; g < 8; g++) begin : g_cov_op
    c_op: cover property (@(posedge clk) past_valid && !past_rst && past_opcode == 3'(g));
  end

  c_carry: cover property (@(posedge clk) VALID && CARRY);
  c_zero:  cover property (@(posedge clk) VALID && ZERO);
  c_neg:   cover property (@(posedge clk) VALID && NEG);
  c_ovf:   cover property (@(posedge clk) VALID && OVF);
`endif

endmodule

// File: tb/tb_alu_core.sv
// Directed self-checking bench for alu_core; packed observation is {RESULT,CARRY,ZERO,NEG,OVF,VALID}.
module tb_alu_core;

  logic       clk;
  logic       rst;
  logic [2:0] OPCODE;
  logic [3:0] OP1;
  logic [3:0] OP2;
  logic [3:0] RESULT;
  logic       CARRY;
  logic       ZERO;
  logic       NEG;
  logic       OVF;
  logic       VALID;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       r;
    logic [8:0] exp;
  } vec_t;

  alu_core #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .OPCODE (OPCODE),
    .OP1    (OP1),
    .OP2    (OP2),
    .RESULT (RESULT),
    .CARRY  (CARRY),
    .ZERO   (ZERO),
    .NEG    (NEG),
    .OVF    (OVF),
    .VALID  (VALID)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] observed();
    return {RESULT, CARRY, ZERO, NEG, OVF, VALID};
  endfunction

  // Drive on the falling edge, let one rising edge sample, then settle 1 time unit.
  task automatic apply(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic r);
    @(negedge clk);
    OPCODE = op;
    OP1    = a;
    OP2    = b;
    rst    = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t v[3];
    v[0] = '{3'b001, 4'b0000, 4'b0000, 1'b1, 9'b0000_0000_0};
    v[1] = '{3'b001, 4'b0000, 4'b0000, 1'b1, 9'b0000_0000_0};
    v[2] = '{3'b001, 4'b0000, 4'b0000, 1'b0, 9'b0000_0100_1};
    for (int i = 0; i < 3; i++) begin
      apply(v[i].op, v[i].a, v[i].b, v[i].r);
      total++;
      if (observed() !== v[i].exp) begin
        bad++;
        $display("FAIL reset[%0d] got=%b expected=%b", i, observed(), v[i].exp);
      end
    end
  endtask

  task automatic test_add_sub();
    vec_t v[6];
    v[0] = '{3'b000, 4'b0111, 4'b0001, 1'b0, 9'b1000_0011_1};
    v[1] = '{3'b000, 4'b1111, 4'b0001, 1'b0, 9'b0000_1100_1};
    v[2] = '{3'b001, 4'b0011, 4'b0101, 1'b0, 9'b1110_1010_1};
    v[3] = '{3'b001, 4'b1000, 4'b0001, 1'b0, 9'b0111_0001_1};
    v[4] = '{3'b001, 4'b0101, 4'b0101, 1'b0, 9'b0000_0100_1};
    v[5] = '{3'b000, 4'b1000, 4'b1000, 1'b0, 9'b0000_1101_1};
    for (int i = 0; i < 6; i++) begin
      apply(v[i].op, v[i].a, v[i].b, v[i].r);
      total++;
      if (observed() !== v[i].exp) begin
        bad++;
        $display("FAIL arith[%0d] got=%b expected=%b", i, observed(), v[i].exp);
      end
    end
  endtask

  task automatic test_logic();
    vec_t v[4];
    v[0] = '{3'b010, 4'b1100, 4'b1010, 1'b0, 9'b1000_0010_1};
    v[1] = '{3'b011, 4'b1100, 4'b1010, 1'b0, 9'b1110_0010_1};
    v[2] = '{3'b100, 4'b1100, 4'b1010, 1'b0, 9'b0110_0000_1};
    v[3] = '{3'b101, 4'b1010, 4'b1111, 1'b0, 9'b0101_0000_1};
    for (int i = 0; i < 4; i++) begin
      apply(v[i].op, v[i].a, v[i].b, v[i].r);
      total++;
      if (observed() !== v[i].exp) begin
        bad++;
        $display("FAIL logic[%0d] got=%b expected=%b", i, observed(), v[i].exp);
      end
    end
  endtask

  task automatic test_shift();
    vec_t v[4];
    v[0] = '{3'b110, 4'b1001, 4'b0000, 1'b0, 9'b0010_1000_1};
    v[1] = '{3'b111, 4'b1001, 4'b0000, 1'b0, 9'b0100_1000_1};
    v[2] = '{3'b111, 4'b0001, 4'b0000, 1'b0, 9'b0000_1100_1};
    v[3] = '{3'b110, 4'b0100, 4'b1111, 1'b0, 9'b1000_0010_1};
    for (int i = 0; i < 4; i++) begin
      apply(v[i].op, v[i].a, v[i].b, v[i].r);
      total++;
      if (observed() !== v[i].exp) begin
        bad++;
        $display("FAIL shift[%0d] got=%b expected=%b", i, observed(), v[i].exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[4];
    v[0] = '{3'b000, 4'b0010, 4'b0011, 1'b0, 9'b0101_0000_1};
    v[1] = '{3'b001, 4'b0110, 4'b0011, 1'b0, 9'b0011_0000_1};
    v[2] = '{3'b100, 4'b1111, 4'b0000, 1'b1, 9'b0000_0000_0};
    v[3] = '{3'b011, 4'b0000, 4'b0001, 1'b0, 9'b0001_0000_1};
    for (int i = 0; i < 4; i++) begin
      apply(v[i].op, v[i].a, v[i].b, v[i].r);
      total++;
      if (observed() !== v[i].exp) begin
        bad++;
        $display("FAIL b2b[%0d] got=%b expected=%b", i, observed(), v[i].exp);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    OPCODE = 3'b001;
    OP1    = '0;
    OP2    = '0;
    test_reset();
    test_add_sub();
    test_logic();
    test_shift();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_core.md
# alu_core

Registered 4-bit arithmetic/logic unit with a 3-bit opcode. Each cycle it samples two operands and an opcode, computes one of eight operations, and registers the result together with carry, zero, negative and overflow flags. It is the leaf datapath block of the small processor/verification demo and is also the target of the block's formal property checks.

## Interface
- WIDTH, 4: operand and result width in bits; the design must support WIDTH ≥ 2.
- clk  input  1: rising-edge clock; the only clock.
- rst  input  1: synchronous reset, active-high, sampled on the rising edge of clk.
- OPCODE  input  3: operation select.
- OP1  input  WIDTH: operand A.
- OP2  input  WIDTH: operand B.
- RESULT  output  WIDTH: registered result.
- CARRY  output  1: registered carry/borrow/shift-out flag.
- ZERO  output  1: registered flag, RESULT == 0.
- NEG  output  1: registered flag, equal to RESULT[WIDTH-1].
- OVF  output  1: registered signed-overflow flag.
- VALID  output  1: high in every cycle in which the outputs hold a computed (non-reset) value.

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SHL, 111 SHR.
- ADD:
  - {CARRY,RESULT} = OP1 + OP2, computed at WIDTH+1 bits.
  - OVF = operand signs equal and result sign differs.
- SUB:
  - RESULT = (OP1 − OP2) mod 2^WIDTH.
  - CARRY = borrow (OP1 < OP2, unsigned).
  - OVF = operand signs differ and result sign differs from OP1.
- AND, OR, XOR: bitwise on OP1 and OP2; CARRY = 0, OVF = 0.
- NOT: RESULT = ~OP1; OP2 is ignored; CARRY = 0, OVF = 0.
- SHL: RESULT = OP1 << 1 with a zero fill; CARRY = OP1[WIDTH-1]; OVF = 0.
- SHR (logical): RESULT = OP1 >> 1 with a zero fill; CARRY = OP1[0]; OVF = 0.
- ZERO and NEG are derived from the new RESULT for every opcode.
- No undefined opcodes exist; all 8 encodings are legal.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Throughput is one operation per cycle; there is no handshake and no stall.
- Reset:
  - rst high at an edge forces RESULT=0, CARRY=0, ZERO=0, NEG=0, OVF=0 and VALID=0, regardless of OP1, OP2 and OPCODE.
  - Reset has priority over computation.
- Reset mid-operation: the operation sampled in a reset cycle is discarded, and the outputs read the reset values on the following cycle.
- First edge with rst low computes normally, and VALID goes high after that edge.
- VALID stays high until the next reset.
- Outputs are undefined before the first reset edge; the bench must apply reset first.

## Configuration
- ALU_FORMAL_EN defined:
  - Embedded assertions check every registered output against a combinational reference model applied to the previous-cycle inputs. The model uses internal past-value registers for OP1, OP2, OPCODE and rst, plus a past-valid bit.
  - Asserts that all outputs are zero while reset is applied.
  - Cover properties hit every opcode, and each of CARRY, ZERO, NEG and OVF set at least once.
- ALU_FORMAL_EN undefined: no past-value registers and no properties are compiled; the functional RTL is identical.

## Structure
- alu_pkg holds:
  - the opcode enum (OP_ADD … OP_SHR, 3 bits);
  - the default WIDTH constant;
  - a flags struct {carry, zero, neg, ovf}.
- Sub-module alu_comb holds the purely combinational datapath (OPCODE, OP1, OP2 → next result and flags).
- alu_core wraps alu_comb with the output registers, the reset logic and the ALU_FORMAL_EN property block.

## Test plan
- Reset hold:
  - Stimulus: rst=1, OPCODE=001, OP1=0000, OP2=0000 for 2 cycles.
  - Required: RESULT=0000, all flags 0, VALID=0.
  - Then rst=0: after one edge RESULT=0000, ZERO=1, VALID=1.
- ADD:
  - 0111+0001 → RESULT=1000, OVF=1, NEG=1, CARRY=0.
  - 1111+0001 → RESULT=0000, CARRY=1, ZERO=1, OVF=0.
- SUB:
  - 0011−0101 → RESULT=1110, CARRY=1, NEG=1.
  - 1000−0001 → RESULT=0111, OVF=1.
- Logic:
  - AND 1100,1010 → 1000; OR → 1110; XOR → 0110.
  - NOT 1010 (OP2=1111) → 0101.
  - CARRY and OVF are 0 for all four.
- Shifts:
  - SHL 1001 → RESULT=0010, CARRY=1.
  - SHR 1001 → RESULT=0100, CARRY=1.
  - SHR 0001 → RESULT=0000, ZERO=1.
- Back-to-back and mid-stream reset:
  - Stimulus: ADD, SUB, XOR on consecutive cycles, with rst=1 on the XOR cycle.
  - Required: ADD and SUB results appear one cycle each, and the XOR result is replaced by reset values.
